pm_min_sel: RTL and testbench

Parametrised, pipelined compare-select unit for the Viterbi decoder back end. It accepts N path metrics plus N data words per beat and picks the data word belonging to the smallest metric, breaking ties towards the lowest index. It outputs that word, the winning index and the minimum metric. The block sits between the ACS/path-metric stage and the traceback/output stage. It replaces the fixed 4-way, 7-bit, single-cycle selector with a log2(N)-deep registered tournament tree and an optional modulo-normalised metric comparison.

---
 rtl/pm_sel_pkg.sv | 33 +++
 rtl/cmp_sel_node.sv | 73 +++++++
 rtl/pm_min_sel.sv | 96 +++++++++
 tb/tb_pm_min_sel.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pm_sel_pkg.sv
// pm_sel_pkg: shared definitions for the pm_min_sel compare-select tree.
//   PM_W_MAX  widest path metric the compare helper handles
//   pm_levels number of registered tree levels for N candidates
//   pm_idx_w  width of the winning-index output for N candidates
//   pm_le     "A is at least as good as B" test used by every tree node
package pm_sel_pkg;

  localparam int unsigned PM_W_MAX = 32;

  function automatic int unsigned pm_levels(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned pm_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // a and b are zero-extended metrics of width w.
  // Modulo mode treats the metrics as points on a circle of size 2^w:
  // A <= B when (B - A) mod 2^w has a clear top bit. Only meaningful while
  // the metric spread stays below 2^(w-1), which the ACS normaliser keeps.
  function automatic logic pm_le(input logic [PM_W_MAX-1:0] a,
                                 input logic [PM_W_MAX-1:0] b,
                                 input int unsigned         w,
                                 input logic                mod_cmp);
    logic [PM_W_MAX-1:0] diff;
    logic [PM_W_MAX-1:0] sh;
    diff = b - a;
    sh   = diff >> (w - 1);
    return mod_cmp ? ~sh[0] : (a <= b);
  endfunction

endpackage

// File: rtl/cmp_sel_node.sv
// cmp_sel_node: one registered compare-select node of the tournament tree.
//   clk, rst          clock, asynchronous active-high reset
//   i_valid           candidates below are meaningful this cycle
//   i_pm_a/i_data_a/i_idx_a   left (lower-index) candidate
//   i_pm_b/i_data_b/i_idx_b   right candidate
//   o_valid           registered copy of i_valid
//   o_pm/o_data/o_idx registered winner; o_idx = {took_right, winner idx}
// IW is the incoming index width (0 at the leaf level, where the incoming
// index ports are present but ignored).
module cmp_sel_node
  import pm_sel_pkg::*;
#(
  parameter int unsigned PM_W    = 7,
  parameter int unsigned D_W     = 8,
  parameter int unsigned IW      = 0,
  parameter int unsigned MOD_CMP = 0,
  localparam int unsigned IWP    = (IW == 0) ? 1 : IW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [PM_W-1:0] i_pm_a,
  input  logic [D_W-1:0]  i_data_a,
  input  logic [IWP-1:0]  i_idx_a,
  input  logic [PM_W-1:0] i_pm_b,
  input  logic [D_W-1:0]  i_data_b,
  input  logic [IWP-1:0]  i_idx_b,
  output logic            o_valid,
  output logic [PM_W-1:0] o_pm,
  output logic [D_W-1:0]  o_data,
  output logic [IW:0]     o_idx
);

  logic            w_a_wins;
  logic [IW:0]     w_idx_nxt;
  logic            r_valid;
  logic [PM_W-1:0] r_pm;
  logic [D_W-1:0]  r_data;
  logic [IW:0]     r_idx;

  // Ties go left, so the lowest path index wins.
  assign w_a_wins = pm_le(PM_W_MAX'(i_pm_a), PM_W_MAX'(i_pm_b), PM_W, (MOD_CMP != 0));

  generate
    if (IW == 0) begin : g_leaf
      assign w_idx_nxt = ~w_a_wins;
    end else begin : g_inner
      assign w_idx_nxt = {~w_a_wins, (w_a_wins ? i_idx_a : i_idx_b)};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pm    <= '0;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_pm   <= w_a_wins ? i_pm_a   : i_pm_b;
        r_data <= w_a_wins ? i_data_a : i_data_b;
        r_idx  <= w_idx_nxt;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pm    = r_pm;
  assign o_data  = r_data;
  assign o_idx   = r_idx;

endmodule

// File: rtl/pm_min_sel.sv
// pm_min_sel: pipelined N-way minimum path-metric selector.
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   beat qualifier for pm_in / data_in
//   pm_in      N metrics, path i at [i*PM_W +: PM_W]
//   data_in    N data words, path i at [i*D_W +: D_W]
//   out_valid  one-cycle pulse per completed beat, log2(N) cycles after input
//   data_out   data word of the winning path
//   idx_out    winning path index (lowest index on ties)
//   pm_min     winning metric
// Outputs hold the last result while out_valid is low.
module pm_min_sel
  import pm_sel_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned PM_W    = 7,
  parameter int unsigned D_W     = 8,
  parameter int unsigned MOD_CMP = 0,
  localparam int unsigned L      = pm_levels(N),
  localparam int unsigned IDX_W  = pm_idx_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N*PM_W-1:0] pm_in,
  input  logic [N*D_W-1:0]  data_in,
  output logic              out_valid,
  output logic [D_W-1:0]    data_out,
  output logic [IDX_W-1:0]  idx_out,
  output logic [PM_W-1:0]   pm_min
);

  // Level k holds N>>k live candidates; unused slots are tied to zero.
  logic             w_valid [0:L];
  logic [PM_W-1:0]  w_pm    [0:L][0:N-1];
  logic [D_W-1:0]   w_data  [0:L][0:N-1];
  logic [IDX_W-1:0] w_idx   [0:L][0:N-1];

  assign w_valid[0] = in_valid;

  generate
    for (genvar i = 0; i < N; i++) begin : g_in
      assign w_pm[0][i]   = pm_in[i*PM_W +: PM_W];
      assign w_data[0][i] = data_in[i*D_W +: D_W];
      assign w_idx[0][i]  = '0;
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int unsigned NODES = N >> (k + 1);
      localparam int unsigned IWP   = (k == 0) ? 1 : k;
      for (genvar j = 0; j < N; j++) begin : g_node
        if (j < NODES) begin : g_cs
          logic       w_v_o;
          logic [k:0] w_idx_o;

          cmp_sel_node #(
            .PM_W    (PM_W),
            .D_W     (D_W),
            .IW      (k),
            .MOD_CMP (MOD_CMP)
          ) u_node (
            .clk      (clk),
            .rst      (rst),
            .i_valid  (w_valid[k]),
            .i_pm_a   (w_pm[k][2*j]),
            .i_data_a (w_data[k][2*j]),
            .i_idx_a  (w_idx[k][2*j][IWP-1:0]),
            .i_pm_b   (w_pm[k][2*j+1]),
            .i_data_b (w_data[k][2*j+1]),
            .i_idx_b  (w_idx[k][2*j+1][IWP-1:0]),
            .o_valid  (w_v_o),
            .o_pm     (w_pm[k+1][j]),
            .o_data   (w_data[k+1][j]),
            .o_idx    (w_idx_o)
          );

          assign w_idx[k+1][j] = IDX_W'(w_idx_o);

          // Every node of a level carries the same valid; node 0's copy feeds on.
          if (j == 0) begin : g_v
            assign w_valid[k+1] = w_v_o;
          end
        end else begin : g_pad
          assign w_pm[k+1][j]   = '0;
          assign w_data[k+1][j] = '0;
          assign w_idx[k+1][j]  = '0;
        end
      end
    end
  endgenerate

  assign out_valid = w_valid[L];
  assign data_out  = w_data[L][0];
  assign idx_out   = w_idx[L][0];
  assign pm_min    = w_pm[L][0];

endmodule

// File: tb/tb_pm_min_sel.sv
// tb_pm_min_sel: bench for pm_min_sel. Four instances run side by side:
//   0: N=4 PM_W=7  D_W=8  unsigned   1: N=4 PM_W=7 D_W=8 modulo
//   2: N=8 PM_W=10 D_W=16 unsigned   3: N=2 PM_W=7 D_W=8 unsigned
// Expected results come from a linear-scan minimum model and a per-instance
// latency delay line.
module tb_pm_min_sel;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic [15:0] idx;
    logic [15:0] pm;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] pmv [4][8];
  logic [15:0] dv  [4][8];
  logic        vin [4];

  int lat [4] = '{2, 2, 3, 1};
  int nn  [4] = '{4, 4, 8, 2};
  int pw  [4] = '{7, 7, 10, 7};
  int dw  [4] = '{8, 8, 16, 8};
  bit md  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  rec_t pipe [4][3];
  rec_t last [4];

  logic [27:0]  pm4, pm4m;
  logic [31:0]  d4, d4m;
  logic [79:0]  pm8;
  logic [127:0] d8;
  logic [13:0]  pm2;
  logic [15:0]  d2;

  logic        v4, v4m, v8, v2;
  logic [7:0]  dd4, dd4m, dd2;
  logic [15:0] dd8;
  logic [1:0]  ix4, ix4m;
  logic [2:0]  ix8;
  logic        ix2;
  logic [6:0]  pp4, pp4m, pp2;
  logic [9:0]  pp8;

  logic        o_v [4];
  logic [15:0] o_d [4];
  logic [15:0] o_i [4];
  logic [15:0] o_p [4];

  always #5 clk = ~clk;

  always_comb begin
    pm4 = '0; pm4m = '0; d4 = '0; d4m = '0; pm8 = '0; d8 = '0; pm2 = '0; d2 = '0;
    for (int i = 0; i < 4; i++) begin
      pm4[i*7 +: 7]  = pmv[0][i][6:0];
      d4[i*8 +: 8]   = dv[0][i][7:0];
      pm4m[i*7 +: 7] = pmv[1][i][6:0];
      d4m[i*8 +: 8]  = dv[1][i][7:0];
    end
    for (int i = 0; i < 8; i++) begin
      pm8[i*10 +: 10] = pmv[2][i][9:0];
      d8[i*16 +: 16]  = dv[2][i];
    end
    for (int i = 0; i < 2; i++) begin
      pm2[i*7 +: 7] = pmv[3][i][6:0];
      d2[i*8 +: 8]  = dv[3][i][7:0];
    end
  end

  always_comb begin
    o_v[0] = v4;  o_d[0] = 16'(dd4);  o_i[0] = 16'(ix4);  o_p[0] = 16'(pp4);
    o_v[1] = v4m; o_d[1] = 16'(dd4m); o_i[1] = 16'(ix4m); o_p[1] = 16'(pp4m);
    o_v[2] = v8;  o_d[2] = dd8;       o_i[2] = 16'(ix8);  o_p[2] = 16'(pp8);
    o_v[3] = v2;  o_d[3] = 16'(dd2);  o_i[3] = 16'(ix2);  o_p[3] = 16'(pp2);
  end

  pm_min_sel #(.N(4), .PM_W(7), .D_W(8), .MOD_CMP(0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .pm_in(pm4), .data_in(d4),
    .out_valid(v4), .data_out(dd4), .idx_out(ix4), .pm_min(pp4));

  pm_min_sel #(.N(4), .PM_W(7), .D_W(8), .MOD_CMP(1)) u_dut4m (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .pm_in(pm4m), .data_in(d4m),
    .out_valid(v4m), .data_out(dd4m), .idx_out(ix4m), .pm_min(pp4m));

  pm_min_sel #(.N(8), .PM_W(10), .D_W(16), .MOD_CMP(0)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(vin[2]), .pm_in(pm8), .data_in(d8),
    .out_valid(v8), .data_out(dd8), .idx_out(ix8), .pm_min(pp8));

  pm_min_sel #(.N(2), .PM_W(7), .D_W(8), .MOD_CMP(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(vin[3]), .pm_in(pm2), .data_in(d2),
    .out_valid(v2), .data_out(dd2), .idx_out(ix2), .pm_min(pp2));

  // Signed distance of x from base on a circle of size 2^w.
  function automatic int rel(input logic [15:0] x, input logic [15:0] base, input int w);
    int r;
    r = (int'(x) - int'(base)) & ((1 << w) - 1);
    if (r >= (1 << (w - 1))) r = r - (1 << w);
    return r;
  endfunction

  // Index of the smallest metric, first occurrence on ties.
  function automatic int ref_idx(input logic [15:0] p[8], input int n, input int w, input bit m);
    int best;
    best = 0;
    for (int i = 1; i < n; i++) begin
      if (m) begin
        if (rel(p[i], p[0], w) < rel(p[best], p[0], w)) best = i;
      end else if (p[i] < p[best]) begin
        best = i;
      end
    end
    return best;
  endfunction

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 3; i++) pipe[d][i] = '0;
      last[d] = '0;
    end
  endtask

  task automatic check_all();
    rec_t e;
    for (int d = 0; d < 4; d++) begin
      e = pipe[d][0];
      if (e.v) last[d] = e;
      chk("out_valid", d, 16'(o_v[d]), 16'(e.v));
      chk("data_out",  d, o_d[d], last[d].d);
      chk("idx_out",   d, o_i[d], last[d].idx);
      chk("pm_min",    d, o_p[d], last[d].pm);
    end
  endtask

  task automatic tick();
    rec_t        r;
    int          ix;
    logic [15:0] tmp [8];
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        for (int i = 0; i < 3; i++) pipe[d][i] = '0;
        last[d] = '0;
      end else begin
        for (int i = 0; i < 8; i++) tmp[i] = pmv[d][i];
        ix    = ref_idx(tmp, nn[d], pw[d], md[d]);
        r.v   = vin[d];
        r.idx = 16'(ix);
        r.d   = dv[d][ix];
        r.pm  = pmv[d][ix];
        for (int i = 0; i < lat[d] - 1; i++) pipe[d][i] = pipe[d][i+1];
        pipe[d][lat[d]-1] = r;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    for (int d = 0; d < 4; d++) vin[d] = 1'b0;
  endtask

  task automatic rand_beat(input bit all_valid);
    int  base;
    bit  tie;
    for (int d = 0; d < 4; d++) begin
      vin[d] = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
      base   = int'($urandom_range(0, 127));
      tie    = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 8; i++) begin
        if (i >= nn[d]) begin
          pmv[d][i] = '0;
          dv[d][i]  = '0;
        end else begin
          dv[d][i] = 16'($urandom & ((1 << dw[d]) - 1));
          if (md[d])
            pmv[d][i] = 16'((base + int'($urandom_range(0, 63))) & 127);
          else if (tie)
            pmv[d][i] = 16'($urandom_range(0, 3));
          else
            pmv[d][i] = 16'($urandom & ((1 << pw[d]) - 1));
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      vin[d] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        pmv[d][i] = '0;
        dv[d][i]  = '0;
      end
    end
    model_reset();

    // Reset state
    #2 rst = 1'b1;
    #1;
    check_all();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed: pm={5,9,3,3}, tie between 2 and 3 goes to 2
    pmv[0][0] = 16'd5; pmv[0][1] = 16'd9; pmv[0][2] = 16'd3; pmv[0][3] = 16'd3;
    dv[0][0] = 16'h11; dv[0][1] = 16'h22; dv[0][2] = 16'h33; dv[0][3] = 16'h44;
    vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    chk("t1_early_valid", 0, 16'(o_v[0]), 16'd0);
    tick();
    chk("t1_valid", 0, 16'(o_v[0]), 16'd1);
    chk("t1_idx",   0, o_i[0], 16'd2);
    chk("t1_data",  0, o_d[0], 16'h33);
    chk("t1_pm",    0, o_p[0], 16'd3);
    tick();
    chk("t1_pulse_end", 0, 16'(o_v[0]), 16'd0);
    chk("t1_hold_idx",  0, o_i[0], 16'd2);

    // Directed: unsigned vs modulo compare on a wrapped metric set
    for (int d = 0; d < 2; d++) begin
      pmv[d][0] = 16'h7E; pmv[d][1] = 16'h02; pmv[d][2] = 16'h10; pmv[d][3] = 16'h20;
      dv[d][0] = 16'hA0; dv[d][1] = 16'hA1; dv[d][2] = 16'hA2; dv[d][3] = 16'hA3;
      vin[d] = 1'b1;
    end
    tick();
    idle();
    tick();
    chk("t2_unsigned_idx",  0, o_i[0], 16'd1);
    chk("t2_unsigned_pm",   0, o_p[0], 16'h02);
    chk("t2_unsigned_data", 0, o_d[0], 16'hA1);
    chk("t2_modulo_idx",    1, o_i[1], 16'd0);
    chk("t2_modulo_pm",     1, o_p[1], 16'h7E);
    chk("t2_modulo_data",   1, o_d[1], 16'hA0);

    // Directed: N=8 all-equal metrics, then only path 7 minimal
    for (int i = 0; i < 8; i++) begin
      pmv[2][i] = 16'h155;
      dv[2][i]  = 16'(16'h1000 + i * 16'h111);
    end
    vin[2] = 1'b1;
    tick();
    vin[2] = 1'b0;
    tick();
    chk("t5_early_valid", 2, 16'(o_v[2]), 16'd0);
    tick();
    chk("t5_valid", 2, 16'(o_v[2]), 16'd1);
    chk("t5_idx",   2, o_i[2], 16'd0);
    chk("t5_data",  2, o_d[2], 16'h1000);
    chk("t5_pm",    2, o_p[2], 16'h155);
    for (int i = 0; i < 7; i++) pmv[2][i] = 16'h3FF;
    pmv[2][7] = 16'h000;
    vin[2] = 1'b1;
    tick();
    vin[2] = 1'b0;
    tick();
    tick();
    chk("t5_last_idx",  2, o_i[2], 16'd7);
    chk("t5_last_data", 2, o_d[2], 16'h1777);
    chk("t5_last_pm",   2, o_p[2], 16'h000);

    // Directed: N=2, one-cycle latency, back-to-back beats
    pmv[3][0] = 16'd4; pmv[3][1] = 16'd4; dv[3][0] = 16'h55; dv[3][1] = 16'h66;
    vin[3] = 1'b1;
    tick();
    chk("t6_tie_valid", 3, 16'(o_v[3]), 16'd1);
    chk("t6_tie_idx",   3, o_i[3], 16'd0);
    chk("t6_tie_data",  3, o_d[3], 16'h55);
    pmv[3][0] = 16'd5;
    tick();
    chk("t6_right_valid", 3, 16'(o_v[3]), 16'd1);
    chk("t6_right_idx",   3, o_i[3], 16'd1);
    chk("t6_right_pm",    3, o_p[3], 16'd4);
    vin[3] = 1'b0;
    tick();
    chk("t6_pulse_end", 3, 16'(o_v[3]), 16'd0);

    // Random streams: valid held high, then valid randomised
    repeat (100) begin
      rand_beat(1'b1);
      tick();
    end
    repeat (100) begin
      rand_beat(1'b0);
      tick();
    end
    idle();
    repeat (4) tick();

    // Asynchronous reset with beats in flight
    rand_beat(1'b1);
    tick();
    rand_beat(1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t4_async_valid", 2, 16'(o_v[2]), 16'd0);
    tick();
    rst = 1'b0;
    idle();
    repeat (3) tick();
    pmv[0][0] = 16'd9; pmv[0][1] = 16'd8; pmv[0][2] = 16'd7; pmv[0][3] = 16'd1;
    dv[0][0] = 16'h01; dv[0][1] = 16'h02; dv[0][2] = 16'h03; dv[0][3] = 16'h04;
    vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    chk("t4_early_valid", 0, 16'(o_v[0]), 16'd0);
    tick();
    chk("t4_valid", 0, 16'(o_v[0]), 16'd1);
    chk("t4_idx",   0, o_i[0], 16'd3);
    chk("t4_data",  0, o_d[0], 16'h04);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
